// File: rtl/norm_packer.sv
// norm_packer: packs the two serial normalized streams into COL-wide row pairs
// and queues them in a DEPTH-row FIFO that drains through a valid/ready port.
module norm_packer #(
    parameter int COL   = 8,
    parameter int W_OUT = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       norm_valid,
    input  logic [W_OUT-1:0]           psum_norm_1,
    input  logic [W_OUT-1:0]           psum_norm_2,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [COL*W_OUT-1:0]       m_data_1,
    output logic [COL*W_OUT-1:0]       m_data_2,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                rows_out
);

    localparam int AW   = $clog2(DEPTH);
    localparam int IDXW = (COL > 1) ? $clog2(COL) : 1;
    localparam int RW   = COL * W_OUT;

    logic [IDXW-1:0] r_idx;
    logic [RW-1:0]   r_asm_1;
    logic [RW-1:0]   r_asm_2;
    logic [RW-1:0]   r_mem_1 [DEPTH];
    logic [RW-1:0]   r_mem_2 [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            r_overflow;
    logic [15:0]     r_rows_out;

    logic [RW-1:0]   w_row_1;
    logic [RW-1:0]   w_row_2;
    logic            w_last;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_accept;

    assign w_last   = (r_idx == IDXW'(COL - 1));
    assign w_push   = norm_valid && w_last;
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop    = m_valid && m_ready;
    // A full FIFO still takes a row when the head leaves on the same edge;
    // the freed slot is exactly the one the write pointer addresses.
    assign w_accept = w_push && (!w_full || w_pop);

    assign m_valid  = (r_wr_ptr != r_rd_ptr);
    assign level    = r_wr_ptr - r_rd_ptr;
    assign m_data_1 = r_mem_1[r_rd_ptr[AW-1:0]];
    assign m_data_2 = r_mem_2[r_rd_ptr[AW-1:0]];
    assign overflow = r_overflow;
    assign rows_out = r_rows_out;

    // Completed row: assembly contents with the current beat bypassed into its column.
    always_comb begin
        w_row_1 = r_asm_1;
        w_row_2 = r_asm_2;
        for (int k = 0; k < COL; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_row_1[k*W_OUT +: W_OUT] = psum_norm_1;
                w_row_2[k*W_OUT +: W_OUT] = psum_norm_2;
            end
        end
    end

    // Beat counter and assembly registers; gaps hold everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_asm_1 <= '0;
            r_asm_2 <= '0;
        end else if (norm_valid) begin
            r_asm_1 <= w_row_1;
            r_asm_2 <= w_row_2;
            r_idx   <= w_last ? '0 : r_idx + IDXW'(1);
        end
    end

    // Row FIFO storage, pointers and status counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_1[i] <= '0;
                r_mem_2[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_rows_out <= '0;
        end else begin
            if (w_accept) begin
                r_mem_1[r_wr_ptr[AW-1:0]] <= w_row_1;
                r_mem_2[r_wr_ptr[AW-1:0]] <= w_row_2;
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + (AW+1)'(1);
                r_rows_out <= r_rows_out + 16'd1;
            end
        end
    end

endmodule
